// File: rtl/mem_arbiter.sv
// Byte-serial memory controller: serves one instruction fetch or one load/store
// at a time over the 8-bit RAM/IO bus and reassembles the bytes little-endian.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [7:0]  mem_result,
  input  logic        io_buffer_full,
  output logic [31:0] mem_a,
  output logic [7:0]  mem_write,
  output logic        is_write,
  input  logic        ic_flag,
  input  logic [31:0] ic_addr,
  output logic [31:0] ic_val,
  output logic        ic_isok,
  input  logic        ls_flag,
  input  logic        ls_wr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_data,
  output logic [31:0] ls_val,
  output logic        ls_isok,
  input  logic        clr
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t      state;
  logic        src_ls;
  logic [31:0] addr;
  logic [31:0] data;
  logic [31:0] rbuf;
  logic [31:0] rbuf_nxt;
  logic [2:0]  n;
  logic [2:0]  cnt;
  logic [31:0] mem_a_q;
  logic        we_q;
  logic        ic_ok_q;
  logic        stall;

  function automatic logic [2:0] size_to_n(input logic [1:0] s);
    case (s)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
    return w[{i, 3'b000} +: 8];
  endfunction

  // A write to the IO window waits while the UART buffer is full; the bus is parked meanwhile.
  assign stall    = (state == WR) && (mem_a_q[17:16] == 2'b11) && io_buffer_full;
  assign mem_a    = stall ? 32'd0 : mem_a_q;
  assign is_write = we_q && rdy && !stall;
  assign ic_isok  = ic_ok_q && !clr;

  // In RD, cnt is the issued-address index; byte cnt-1 arrives on mem_result.
  always_comb begin
    rbuf_nxt = rbuf;
    for (int b = 0; b < 4; b++) begin
      if (cnt == 3'(b + 1)) rbuf_nxt[8*b +: 8] = mem_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      src_ls    <= 1'b0;
      cnt       <= 3'd0;
      mem_a_q   <= 32'd0;
      mem_write <= 8'd0;
      we_q      <= 1'b0;
      ic_val    <= 32'd0;
      ic_ok_q   <= 1'b0;
      ls_val    <= 32'd0;
      ls_isok   <= 1'b0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          if (!clr && (ls_flag || ic_flag)) begin
            cnt  <= 3'd0;
            rbuf <= 32'd0;
            if (ls_flag) begin
              src_ls  <= 1'b1;
              addr    <= ls_addr;
              data    <= ls_data;
              n       <= size_to_n(ls_size);
              mem_a_q <= ls_addr;
              if (ls_wr) begin
                state     <= WR;
                we_q      <= 1'b1;
                mem_write <= ls_data[7:0];
              end else begin
                state <= RD;
              end
            end else begin
              src_ls  <= 1'b0;
              addr    <= ic_addr;
              n       <= 3'd4;
              mem_a_q <= ic_addr;
              state   <= RD;
            end
          end
        end
        RD: begin
          if (clr && (!src_ls || addr[17:16] != 2'b11)) begin
            state   <= IDLE;
            mem_a_q <= 32'd0;
          end else begin
            rbuf <= rbuf_nxt;
            if (cnt == n) begin
              state <= DONE;
              if (src_ls) begin
                ls_val  <= rbuf_nxt;
                ls_isok <= 1'b1;
              end else begin
                ic_val  <= rbuf_nxt;
                ic_ok_q <= 1'b1;
              end
            end else begin
              cnt     <= cnt + 3'd1;
              mem_a_q <= ((cnt + 3'd1) == n) ? 32'd0 : addr + {29'd0, cnt} + 32'd1;
            end
          end
        end
        WR: begin
          if (!stall) begin
            if (cnt == n - 3'd1) begin
              state     <= DONE;
              we_q      <= 1'b0;
              mem_a_q   <= 32'd0;
              mem_write <= 8'd0;
              ls_val    <= 32'd0;
              ls_isok   <= 1'b1;
            end else begin
              cnt       <= cnt + 3'd1;
              mem_a_q   <= addr + {29'd0, cnt} + 32'd1;
              mem_write <= byte_of(data, cnt[1:0] + 2'd1);
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          cnt     <= 3'd0;
          ic_ok_q <= 1'b0;
          ls_isok <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
